// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared state encoding and sizing helpers for the chunked CLA sequencer
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index width for n chunks, never narrower than one bit
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/cla_chunk_sequencer_if.sv
// rtl/cla_chunk_sequencer_if.sv - operand/result handshake bundle for the chunked CLA sequencer
interface cla_chunk_sequencer_if
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NCHUNK = 4
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              CIN;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [WIDTH-1:0]  SUM;
    logic              COUT;
    logic [NCHUNK-1:0] CHUNK_GG;
    logic              BUSY;

    modport master (
        output IN_VALID, A, B, CIN, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, COUT, CHUNK_GG, BUSY
    );

    modport slave (
        input  IN_VALID, A, B, CIN, OUT_READY,
        output IN_READY, OUT_VALID, SUM, COUT, CHUNK_GG, BUSY
    );
endinterface

// File: rtl/cla_chunk.sv
// rtl/cla_chunk.sv - combinational CHUNK-bit carry-lookahead adder slice
module cla_chunk
    import cla_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] A,
    input  logic [CHUNK-1:0] B,
    input  logic             CI,
    output logic [CHUNK-1:0] S,
    output logic             CO,
    output logic             GG,
    output logic             GP
);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic             gg_acc;
    logic             gp_acc;
    logic             c_bit;

    assign g = A & B;
    assign p = A ^ B;

    // Fold bit generate/propagate into group terms; carry-out is one lookahead term on CI
    always_comb begin
        gg_acc = 1'b0;
        gp_acc = 1'b1;
        for (int i = 0; i < CHUNK; i++) begin
            gg_acc = g[i] | (p[i] & gg_acc);
            gp_acc = gp_acc & p[i];
        end
        GG = gg_acc;
        GP = gp_acc;
        CO = gg_acc | (gp_acc & CI);
    end

    // Per-bit sum from the carry entering each bit position
    always_comb begin
        S     = '0;
        c_bit = CI;
        for (int i = 0; i < CHUNK; i++) begin
            S[i]  = p[i] ^ c_bit;
            c_bit = g[i] | (p[i] & c_bit);
        end
    end
endmodule

// File: rtl/cla_chunk_sequencer.sv
// rtl/cla_chunk_sequencer.sv - time-shares one chunk adder across a wide add, LSB chunk first
module cla_chunk_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CHUNK         = 8,
    parameter int APPROX_CHUNKS = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    cla_chunk_sequencer_if.slave bus
);
    localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);
    // Bit k set means the carry leaving chunk k is dropped
    localparam logic [NCHUNK-1:0] CUT_MASK = NCHUNK'((64'd1 << APPROX_CHUNKS) - 64'd1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $fatal(1, "cla_chunk_sequencer: WIDTH must be a multiple of CHUNK");
    end
    if ((APPROX_CHUNKS < 0) || (APPROX_CHUNKS >= NCHUNK)) begin : g_bad_approx
        $fatal(1, "cla_chunk_sequencer: APPROX_CHUNKS must lie in 0..NCHUNK-1");
    end

    typedef logic [NCHUNK-1:0][CHUNK-1:0] word_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    word_t             a_q;
    word_t             b_q;
    word_t             sum_q;
    logic [NCHUNK-1:0] gg_q;
    logic              carry_q;
    logic              cout_q;
    logic              last;
    logic              in_ready;
    logic              out_valid;
    logic              busy;

    logic [CHUNK-1:0]  ck_s;
    logic              ck_co;
    logic              ck_gg;
    logic              ck_gp;
    logic              unused_gp;

    assign last      = (idx_q == IDX_W'(NCHUNK - 1));
    assign unused_gp = ck_gp;

    cla_chunk #(.CHUNK(CHUNK)) u_chunk (
        .A  (a_q[idx_q]),
        .B  (b_q[idx_q]),
        .CI (carry_q),
        .S  (ck_s),
        .CO (ck_co),
        .GG (ck_gg),
        .GP (ck_gp)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.IN_VALID) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, per-chunk result write-back and carry chaining
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            gg_q    <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        carry_q <= bus.CIN;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        gg_q    <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= ck_s;
                    gg_q[idx_q]  <= ck_gg;
                    carry_q      <= ck_co & ~CUT_MASK[idx_q];
                    if (last) cout_q <= ck_co;
                    else      idx_q  <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.BUSY      = busy;
    assign bus.SUM       = sum_q;
    assign bus.COUT      = cout_q;
    assign bus.CHUNK_GG  = gg_q;
endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// tb/tb_cla_chunk_sequencer.sv - directed and random checks of the chunked CLA sequencer
module tb_cla_chunk_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cla_chunk_sequencer_if #(.WIDTH(32), .NCHUNK(4)) b0 ();
    cla_chunk_sequencer_if #(.WIDTH(32), .NCHUNK(4)) b1 ();

    cla_chunk_sequencer #(.WIDTH(32), .CHUNK(8), .APPROX_CHUNKS(0)) dut0 (
        .CLK (clk),
        .RST (rst),
        .bus (b0)
    );

    cla_chunk_sequencer #(.WIDTH(32), .CHUNK(8), .APPROX_CHUNKS(1)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (b1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        if (sel == 0) begin
            b0.IN_VALID = v; b0.A = a; b0.B = b; b0.CIN = c;
        end else begin
            b1.IN_VALID = v; b1.A = a; b1.B = b; b1.CIN = c;
        end
    endtask

    task automatic set_ordy(input int sel, input logic v);
        if (sel == 0) b0.OUT_READY = v;
        else          b1.OUT_READY = v;
    endtask

    function automatic logic ov(input int sel);
        return (sel == 0) ? b0.OUT_VALID : b1.OUT_VALID;
    endfunction

    // Accept one operand set and count edges until the result is offered
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic c, output int lat);
        drive(sel, 1'b1, a, b, c);
        tick();
        drive(sel, 1'b0, a, b, c);
        lat = 0;
        while (!ov(sel) && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input int sel);
        set_ordy(sel, 1'b1);
        tick();
        set_ordy(sel, 1'b0);
    endtask

    function automatic logic [3:0] gg_model(input logic [31:0] a, input logic [31:0] b);
        logic [8:0] s9;
        logic [3:0] g;
        for (int k = 0; k < 4; k++) begin
            s9   = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]};
            g[k] = s9[8];
        end
        return g;
    endfunction

    initial begin
        int          lat;
        int          t;
        int          nacc;
        int          nres;
        int          last_acc;
        int          overlap;
        int          k;
        logic        accepting;
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        logic        pc [3];
        logic [32:0] pexp [3];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] rexp;

        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready",  64'(b0.IN_READY),  64'd1);
        check("rst_out_valid", 64'(b0.OUT_VALID), 64'd0);
        check("rst_sum",       64'(b0.SUM),       64'd0);
        check("rst_cout",      64'(b0.COUT),      64'd0);
        check("rst_gg",        64'(b0.CHUNK_GG),  64'd0);
        check("rst_busy",      64'(b0.BUSY),      64'd0);

        // Carry ripples through every chunk
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check("ripple_lat",      64'(lat),         64'd4);
        check("ripple_sum",      64'(b0.SUM),      64'h0);
        check("ripple_cout",     64'(b0.COUT),     64'd1);
        check("ripple_gg",       64'(b0.CHUNK_GG), 64'b0001);
        check("ripple_in_ready", 64'(b0.IN_READY), 64'd0);
        check("ripple_busy",     64'(b0.BUSY),     64'd1);
        handshake(0);
        check("ripple_post_ready", 64'(b0.IN_READY),  64'd1);
        check("ripple_post_valid", 64'(b0.OUT_VALID), 64'd0);

        // Carry cut above chunk 0 versus exact mode
        run_op(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
        check("approx_lat",  64'(lat),         64'd4);
        check("approx_sum",  64'(b1.SUM),      64'h0);
        check("approx_cout", 64'(b1.COUT),     64'd0);
        check("approx_gg",   64'(b1.CHUNK_GG), 64'b0001);
        handshake(1);
        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
        check("exact_sum",  64'(b0.SUM),      64'h100);
        check("exact_cout", 64'(b0.COUT),     64'd0);
        check("exact_gg",   64'(b0.CHUNK_GG), 64'b0001);
        handshake(0);

        // Back-pressure with a competing request that must be ignored
        run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, lat);
        check("bp_sum",  64'(b0.SUM),      64'h2345_678A);
        check("bp_cout", 64'(b0.COUT),     64'd0);
        check("bp_gg",   64'(b0.CHUNK_GG), 64'd0);
        drive(0, 1'b1, 32'hCAFE_F00D, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_sum",   64'(b0.SUM),       64'h2345_678A);
            check("bp_hold_ready", 64'(b0.IN_READY),  64'd0);
            check("bp_hold_valid", 64'(b0.OUT_VALID), 64'd1);
        end
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        handshake(0);
        check("bp_post_ready", 64'(b0.IN_READY), 64'd1);
        check("bp_post_sum",   64'(b0.SUM),      64'h2345_678A);

        // Reset on the second RUN edge discards the operation
        drive(0, 1'b1, 32'h0101_0101, 32'h0202_0202, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 64'(b0.OUT_VALID), 64'd0);
        check("mrst_sum",   64'(b0.SUM),       64'd0);
        check("mrst_gg",    64'(b0.CHUNK_GG),  64'd0);
        check("mrst_ready", 64'(b0.IN_READY),  64'd1);
        repeat (6) tick();
        check("mrst_no_late_result", 64'(b0.OUT_VALID), 64'd0);
        run_op(0, 32'd5, 32'd7, 1'b0, lat);
        check("fresh_lat",  64'(lat),     64'd4);
        check("fresh_sum",  64'(b0.SUM),  64'd12);
        check("fresh_cout", 64'(b0.COUT), 64'd0);

        // Reset beats a result handshake on the same edge
        set_ordy(0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ordy(0, 1'b0);
        check("rst_vs_hs_sum",   64'(b0.SUM),       64'd0);
        check("rst_vs_hs_valid", 64'(b0.OUT_VALID), 64'd0);

        // Reset beats an operand accept on the same edge
        drive(0, 1'b1, 32'd1, 32'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rst_vs_acc_busy", 64'(b0.BUSY), 64'd0);

        // Back-to-back operations with the request held high
        pa[0] = 32'h0000_0001; pb[0] = 32'h0000_0002; pc[0] = 1'b0; pexp[0] = 33'h0_0000_0003;
        pa[1] = 32'h8000_0000; pb[1] = 32'h8000_0000; pc[1] = 1'b1; pexp[1] = 33'h1_0000_0001;
        pa[2] = 32'hDEAD_BEEF; pb[2] = 32'h0102_0304; pc[2] = 1'b0; pexp[2] = 33'h0_DFAF_C1F3;
        set_ordy(0, 1'b1);
        drive(0, 1'b1, pa[0], pb[0], pc[0]);
        nacc = 0; nres = 0; t = 0; last_acc = 0; overlap = 0;
        while (nres < 3 && t < 100) begin
            if (b0.OUT_VALID) begin
                check("b2b_result", 64'({b0.COUT, b0.SUM}), 64'(pexp[nres]));
                nres++;
            end
            if (b0.IN_READY && b0.BUSY) overlap++;
            accepting = b0.IN_READY && b0.IN_VALID;
            tick();
            t++;
            if (accepting) begin
                if (nacc > 0) check("b2b_spacing", 64'(t - last_acc), 64'd6);
                last_acc = t;
                nacc++;
                if (nacc < 3) drive(0, 1'b1, pa[nacc], pb[nacc], pc[nacc]);
                else          drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
            end
        end
        check("b2b_results", 64'(nres),    64'd3);
        check("b2b_overlap", 64'(overlap), 64'd0);
        set_ordy(0, 1'b0);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Random exact-mode regression with consumer stalls
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            set_ordy(0, 1'($urandom_range(0, 1)));
            run_op(0, ra, rb, rc, lat);
            set_ordy(0, 1'b0);
            rexp = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            check("rnd_lat", 64'(lat), 64'd4);
            check("rnd_sum", 64'({b0.COUT, b0.SUM}), 64'(rexp));
            check("rnd_gg",  64'(b0.CHUNK_GG), 64'(gg_model(ra, rb)));
            k = $urandom_range(0, 3);
            repeat (k) tick();
            check("rnd_hold", 64'({b0.OUT_VALID, b0.COUT, b0.SUM}), 64'({1'b1, rexp}));
            handshake(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
